multi_chan_cmd_fsm: RTL and testbench

Parametrised Moore command decoder, successor to the single-output 2-bit sequence detector. It watches a symbol stream `ain = {channel, opcode}` and latches a command when a non-zero opcode arrives. The command commits only after QUIET consecutive quiet symbols. On commit it sets, clears or toggles one of CH held output bits. It sits between the input synchroniser and the LED/actuator drive logic.

---
 rtl/cmd_fsm_pkg.sv | 16 +
 rtl/multi_chan_cmd_fsm_quiet_counter.sv | 26 ++
 rtl/multi_chan_cmd_fsm.sv | 111 +++++++++++
 tb/tb_multi_chan_cmd_fsm.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cmd_fsm_pkg.sv
// Shared opcode and state encodings for the multi-channel command decoder.
package cmd_fsm_pkg;

   localparam logic [1:0] OP_QUIET  = 2'b00;
   localparam logic [1:0] OP_CLEAR  = 2'b01;
   localparam logic [1:0] OP_TOGGLE = 2'b10;
   localparam logic [1:0] OP_SET    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ARMED  = 2'b01,
      ST_COMMIT = 2'b10,
      ST_ERROR  = 2'b11
   } state_e;

endpackage

// File: rtl/multi_chan_cmd_fsm_quiet_counter.sv
// Counts consecutive quiet symbols while a command is armed; hit flags the last
// quiet symbol needed before commit.
module quiet_counter #(
   parameter  int QUIET = 2,
   localparam int QW    = $clog2(QUIET + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam logic [QW-1:0] LAST = QW'(QUIET - 1);

   logic [QW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset)      cnt_q <= '0;
      else if (clr_i)  cnt_q <= '0;
      else if (inc_i)  cnt_q <= cnt_q + 1'b1;
   end

   assign hit_o = (cnt_q == LAST);

endmodule

// File: rtl/multi_chan_cmd_fsm.sv
// Moore command decoder: latches {channel, opcode}, commits after QUIET quiet
// symbols and sets/clears/toggles one held output bit.
module multi_chan_cmd_fsm
   import cmd_fsm_pkg::*;
#(
   parameter  int CH    = 4,
   parameter  int QUIET = 2,
   localparam int CHW   = $clog2(CH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [CHW+1:0] ain,
   output logic [CH-1:0]  yout,
   output logic           pending,
   output logic           cmd_done,
   output logic           cmd_err
);

   localparam logic [CHW:0] CH_L = CH[CHW:0];

   state_e          state_q;
   logic [1:0]      cmd_op_q;
   logic [CHW-1:0]  cmd_ch_q;
   logic [CH-1:0]   yout_q;
   logic            pending_q, done_q, err_q;

   logic [1:0]      op;
   logic [CHW-1:0]  ch;
   logic            quiet_sym, hit, cnt_clr, cnt_inc, ch_ok;

   assign op        = ain[1:0];
   assign ch        = ain[CHW+1:2];
   assign quiet_sym = (op == OP_QUIET);
   assign ch_ok     = ({1'b0, cmd_ch_q} < CH_L);

   // Any fresh latch restarts the count; a commit also clears it.
   always_comb begin
      cnt_clr = !quiet_sym || (state_q == ST_ARMED && hit);
      cnt_inc = (state_q == ST_ARMED) && quiet_sym && !hit;
   end

   quiet_counter #(.QUIET(QUIET)) u_qcnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .hit_o (hit)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cmd_op_q  <= '0;
         cmd_ch_q  <= '0;
         yout_q    <= '0;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            ST_ARMED: begin
               if (!quiet_sym) begin
                  cmd_op_q  <= op;
                  cmd_ch_q  <= ch;
                  pending_q <= 1'b1;
               end else if (hit) begin
                  if (ch_ok) begin
                     for (int i = 0; i < CH; i++) begin
                        if (cmd_ch_q == i[CHW-1:0]) begin
                           case (cmd_op_q)
                              OP_SET:    yout_q[i] <= 1'b1;
                              OP_CLEAR:  yout_q[i] <= 1'b0;
                              OP_TOGGLE: yout_q[i] <= ~yout_q[i];
                              default:   yout_q[i] <= yout_q[i];
                           endcase
                        end
                     end
                     state_q <= ST_COMMIT;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ERROR;
                     err_q   <= 1'b1;
                  end
               end else begin
                  pending_q <= 1'b1;
               end
            end
            // IDLE, COMMIT and ERROR all accept a new command immediately.
            default: begin
               if (!quiet_sym) begin
                  cmd_op_q  <= op;
                  cmd_ch_q  <= ch;
                  state_q   <= ST_ARMED;
                  pending_q <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign yout     = yout_q;
   assign pending  = pending_q;
   assign cmd_done = done_q;
   assign cmd_err  = err_q;

endmodule

// File: tb/tb_multi_chan_cmd_fsm.sv
// Directed vector bench for multi_chan_cmd_fsm: default build, CH=3 and QUIET=1.
module tb_multi_chan_cmd_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] ain = '0, ain3 = '0, ain1 = '0;

   logic [3:0] yout, yout1;
   logic [2:0] yout3;
   logic       pend, done, err, pend3, done3, err3, pend1, done1, err1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_chan_cmd_fsm #(.CH(4), .QUIET(2)) dut (
      .clk(clk), .reset(reset), .ain(ain), .yout(yout),
      .pending(pend), .cmd_done(done), .cmd_err(err));

   multi_chan_cmd_fsm #(.CH(3), .QUIET(2)) dut3 (
      .clk(clk), .reset(reset), .ain(ain3), .yout(yout3),
      .pending(pend3), .cmd_done(done3), .cmd_err(err3));

   multi_chan_cmd_fsm #(.CH(4), .QUIET(1)) dut1 (
      .clk(clk), .reset(reset), .ain(ain1), .yout(yout1),
      .pending(pend1), .cmd_done(done1), .cmd_err(err1));

   typedef struct {
      logic       rst_n;
      logic [3:0] a;
      logic [3:0] y;
      logic       p, d, e;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic [3:0] a, input logic [3:0] y,
                      input logic p, input logic d, input logic e);
      vec_t v;
      v.rst_n = r; v.a = a; v.y = y; v.p = p; v.d = d; v.e = e;
      vt.push_back(v);
   endtask

   task automatic step(input logic r, input logic [3:0] a, input logic [3:0] a3,
                       input logic [3:0] a1);
      @(negedge clk);
      reset = r; ain = a; ain3 = a3; ain1 = a1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got y/p/d/e=%b required %b", name, act, exp);
      end
   endtask

   initial begin
      // Reset
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // 1: set ch2
      add(1, 4'b1011, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0100, 0, 1, 0);
      add(1, 4'b0000, 4'b0100, 0, 0, 0);
      // quiet symbols with channel bits set never disturb IDLE
      add(1, 4'b1100, 4'b0100, 0, 0, 0);
      // 2: toggle ch2 twice from reset
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b1010, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0100, 0, 1, 0);
      add(1, 4'b0000, 4'b0100, 0, 0, 0);
      add(1, 4'b1010, 4'b0100, 1, 0, 0);
      add(1, 4'b0000, 4'b0100, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 1, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      // 3: interrupted command, last one wins
      add(1, 4'b1011, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 0, 0);
      add(1, 4'b0111, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0010, 0, 1, 0);
      add(1, 4'b0000, 4'b0010, 0, 0, 0);
      // clear ch1
      add(1, 4'b0101, 4'b0010, 1, 0, 0);
      add(1, 4'b0000, 4'b0010, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 1, 0);
      // 4: back-to-back, second command sampled in COMMIT
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0011, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 0, 0);
      add(1, 4'b0000, 4'b0001, 0, 1, 0);
      add(1, 4'b1111, 4'b0001, 1, 0, 0);
      add(1, 4'b0000, 4'b0001, 1, 0, 0);
      add(1, 4'b0000, 4'b1001, 0, 1, 0);
      add(1, 4'b0000, 4'b1001, 0, 0, 0);
      // 5: reset on what would be the commit edge
      add(1, 4'b1011, 4'b1001, 1, 0, 0);
      add(1, 4'b0000, 4'b1001, 1, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].rst_n, vt[i].a, 4'b0000, 4'b0000);
         chk($sformatf("vec%0d", i), {yout, pend, done, err},
             {vt[i].y, vt[i].p, vt[i].d, vt[i].e});
      end

      // CH=3 error path and QUIET=1 single-quiet commit, run side by side
      step(0, 4'b0000, 4'b0000, 4'b0000);
      chk("c3_rst", {1'b0, yout3, pend3, done3, err3}, 7'b0000_000);
      chk("q1_rst", {yout1, pend1, done1, err1}, 7'b0000_000);
      step(1, 4'b0000, 4'b1111, 4'b0111);
      chk("c3_arm", {1'b0, yout3, pend3, done3, err3}, 7'b0000_100);
      chk("q1_arm", {yout1, pend1, done1, err1}, 7'b0000_100);
      step(1, 4'b0000, 4'b0000, 4'b0000);
      chk("c3_wait", {1'b0, yout3, pend3, done3, err3}, 7'b0000_100);
      chk("q1_commit", {yout1, pend1, done1, err1}, 7'b0010_010);
      step(1, 4'b0000, 4'b0000, 4'b1110);
      chk("c3_err", {1'b0, yout3, pend3, done3, err3}, 7'b0000_001);
      chk("q1_b2b", {yout1, pend1, done1, err1}, 7'b0010_100);
      step(1, 4'b0000, 4'b1011, 4'b0000);
      chk("c3_err_end", {1'b0, yout3, pend3, done3, err3}, 7'b0000_100);
      chk("q1_toggle", {yout1, pend1, done1, err1}, 7'b1010_010);
      step(1, 4'b0000, 4'b0000, 4'b0000);
      chk("c3_wait2", {1'b0, yout3, pend3, done3, err3}, 7'b0000_100);
      chk("q1_idle", {yout1, pend1, done1, err1}, 7'b1010_000);
      step(1, 4'b0000, 4'b0000, 4'b0000);
      chk("c3_set2", {1'b0, yout3, pend3, done3, err3}, 7'b0100_010);
      step(1, 4'b0000, 4'b0000, 4'b0000);
      chk("c3_idle", {1'b0, yout3, pend3, done3, err3}, 7'b0100_000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
